esop_cube_sequencer: RTL
========================

# esop_cube_sequencer

Sequential evaluator for single-output ESOP (exclusive-sum-of-products) functions over `NUM_VARS` inputs. It holds a programmable cube list and evaluates one cube per cycle against a latched input vector, XOR-accumulating the cube outcomes into the function value. It sits beside the flat combinational ESOP benchmarks as the time-multiplexed, reconfigurable alternative. Benches and higher-level controllers use it to evaluate arbitrary ESOP covers without re-synthesis.

## Interface
Parameters:
- `NUM_VARS`, 10, number of input variables; bit i of every vector is variable x_i.
- `MAX_CUBES`, 32, cube-list capacity; CW = $clog2(MAX_CUBES).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_we`  in  1  write cube `cfg_addr`.
- `cfg_addr`  in  CW  cube index.
- `cfg_care`  in  NUM_VARS  1 = variable appears in the cube.
- `cfg_pol`  in  NUM_VARS  required literal value for cared variables; ignored where care = 0.
- `cfg_num_we`  in  1  load the active cube count.
- `cfg_num`  in  CW+1  active cube count, 0..MAX_CUBES.
- `cfg_err`  out  1  one-cycle pulse: a config write was dropped.
- `in_valid`  in  1  input vector offered.
- `in_ready`  out  1  block accepts a vector.
- `in_x`  in  NUM_VARS  input vector.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_f`  out  1  ESOP value.
- `out_hits`  out  CW+1  number of cubes that evaluated to 1.

## Operation
- Cube k matches iff `((x ^ pol[k]) & care[k]) == 0`. A cube with care = 0 is constant 1.
- f = XOR over k < num_cubes of match(k). out_hits = popcount of the matches, so out_f = out_hits[0].
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch in_x, clear the accumulator and hit count, set idx = 0. Go to DONE if num_cubes = 0, else to EVAL.
  - EVAL: each cycle, evaluate cube idx; acc ^= match; hits += match; idx++. After cube num_cubes−1 is evaluated, go to DONE.
  - DONE: out_valid = 1; out_f and out_hits are held stable. On out_ready, go to IDLE.
- in_ready = 1 only in IDLE. There is no bypass from DONE to IDLE: a new vector is accepted at the earliest in the cycle after the output handshake.
- Config writes are accepted only in IDLE. In EVAL or DONE, a write (cfg_we or cfg_num_we) is dropped and cfg_err pulses on the following cycle.
- A config write and an in_valid accept in the same IDLE cycle: the write takes effect, and this evaluation already uses the new cube and count.
- cfg_num > MAX_CUBES saturates to MAX_CUBES. cfg_addr ≥ MAX_CUBES is dropped with cfg_err (only relevant when MAX_CUBES is not a power of two).
- out_hits width CW+1 covers the maximum of MAX_CUBES without wrap.

## Timing
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_f = 0, out_hits = 0, cfg_err = 0, num_cubes = 0, all care = 0, all pol = 0.
- Latency from the accept edge to out_valid high is num_cubes + 1 cycles. For num_cubes = 0 it is 1 cycle, with out_f = 0 and out_hits = 0.
- Throughput is one vector per num_cubes + 2 cycles when out_ready is held high.
- out_valid stays high with stable data until out_ready is sampled high. out_valid and in_ready are never both high.
- rst_n asserted mid-EVAL or mid-DONE aborts the evaluation and the result is lost. The cube list is also cleared, so software must reprogram it.

## Structure
- Package `esop_pkg` holds:
  - `NUM_VARS_DEF`, `MAX_CUBES_DEF`.
  - `cube_t` struct {care, pol}.
  - `esop_state_e` enum {IDLE, EVAL, DONE}.
- Sub-module `esop_cube_match`: combinational single-cube match (care, pol, x → match). The sequencer instantiates it once, on the cube-memory read port.
- The cube store is a flop array (MAX_CUBES × 2·NUM_VARS) so that it can be reset asynchronously.

## Test plan
- Reset: assert rst_n low mid-EVAL → outputs take their reset values immediately; in_ready = 1 on the first cycle after release; the next vector yields out_f = 0, out_hits = 0 (count cleared).
- Program cube0 care = 0x200, pol = 0x200 and cube1 care = 0x018, pol = 0x000; num = 2. Then:
  - in_x = 0x208 → out_valid 3 cycles after accept, out_f = 1, out_hits = 1.
  - in_x = 0x200 → out_f = 0, out_hits = 2.
- num = 0 with in_x = 0x3FF → out_valid 1 cycle after accept, out_f = 0, out_hits = 0.
- All 32 cubes set to care = 0 → out_hits = 32, out_f = 0, latency 33 cycles. Then num = 31 → out_f = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → out_valid and data stable, in_ready = 0. Drive cfg_we in that window → cube unchanged and cfg_err pulses once.
- Exhaustive sweep of all 1024 vectors against a reference-model ESOP of 20 random cubes → zero mismatches. Also check same-cycle cfg_we plus in_valid in IDLE → the result uses the new cube.

Source files
------------

// File: rtl/esop_pkg.sv
// Shared types and defaults for the sequential ESOP cube evaluator.
package esop_pkg;

    localparam int NUM_VARS_DEF  = 10;
    localparam int MAX_CUBES_DEF = 32;

    typedef struct packed {
        logic [NUM_VARS_DEF-1:0] care;
        logic [NUM_VARS_DEF-1:0] pol;
    } cube_t;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } esop_state_e;

endpackage

// File: rtl/esop_cube_sequencer_if.sv
// Configuration, input-vector and result handshake bundle of the ESOP sequencer.
interface esop_cube_sequencer_if
    import esop_pkg::*;
#(
    parameter int NUM_VARS  = NUM_VARS_DEF,
    parameter int MAX_CUBES = MAX_CUBES_DEF
);
    localparam int CW = $clog2(MAX_CUBES);

    logic                cfg_we;
    logic [CW-1:0]       cfg_addr;
    logic [NUM_VARS-1:0] cfg_care;
    logic [NUM_VARS-1:0] cfg_pol;
    logic                cfg_num_we;
    logic [CW:0]         cfg_num;
    logic                cfg_err;
    logic                in_valid;
    logic                in_ready;
    logic [NUM_VARS-1:0] in_x;
    logic                out_valid;
    logic                out_ready;
    logic                out_f;
    logic [CW:0]         out_hits;

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_pol, cfg_num_we, cfg_num,
        input  in_valid, in_x, out_ready,
        output cfg_err, in_ready, out_valid, out_f, out_hits
    );

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_pol, cfg_num_we, cfg_num,
        output in_valid, in_x, out_ready,
        input  cfg_err, in_ready, out_valid, out_f, out_hits
    );

endinterface

// File: rtl/esop_cube_match.sv
// Combinational single-cube test: the cube matches when every cared variable equals its polarity.
module esop_cube_match
    import esop_pkg::*;
#(
    parameter int NUM_VARS = NUM_VARS_DEF
) (
    input  logic [NUM_VARS-1:0] i_care,
    input  logic [NUM_VARS-1:0] i_pol,
    input  logic [NUM_VARS-1:0] i_x,
    output logic                o_match
);

    assign o_match = ~|((i_x ^ i_pol) & i_care);

endmodule

// File: rtl/esop_cube_sequencer.sv
// Time-multiplexed ESOP evaluator: one programmable cube per cycle, XOR/popcount accumulated.
module esop_cube_sequencer
    import esop_pkg::*;
#(
    parameter int NUM_VARS  = NUM_VARS_DEF,
    parameter int MAX_CUBES = MAX_CUBES_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    esop_cube_sequencer_if.slave bus
);

    localparam int          CW      = $clog2(MAX_CUBES);
    localparam logic [CW:0] MAX_CNT = (CW+1)'(MAX_CUBES);

    esop_state_e r_state;
    esop_state_e w_next;

    logic [MAX_CUBES-1:0][NUM_VARS-1:0] r_care;
    logic [MAX_CUBES-1:0][NUM_VARS-1:0] r_pol;
    logic [CW:0]                        r_num;
    logic [CW-1:0]                      r_idx;
    logic [NUM_VARS-1:0]                r_x;
    logic                               r_acc;
    logic [CW:0]                        r_hits;
    logic                               r_cfg_err;

    logic        w_idle;
    logic        w_eval;
    logic        w_accept;
    logic        w_addr_ok;
    logic        w_cube_wr;
    logic        w_num_wr;
    logic        w_drop;
    logic        w_last;
    logic        w_match;
    logic [CW:0] w_num_sat;
    logic [CW:0] w_num_eff;

    assign w_idle    = (r_state == IDLE);
    assign w_eval    = (r_state == EVAL);
    assign w_accept  = w_idle & bus.in_valid;
    assign w_addr_ok = ({1'b0, bus.cfg_addr} < MAX_CNT);
    assign w_cube_wr = bus.cfg_we & w_idle & w_addr_ok;
    assign w_num_wr  = bus.cfg_num_we & w_idle;
    assign w_drop    = (bus.cfg_we & ~(w_idle & w_addr_ok)) | (bus.cfg_num_we & ~w_idle);
    assign w_num_sat = (bus.cfg_num > MAX_CNT) ? MAX_CNT : bus.cfg_num;
    // A count written in the accept cycle already governs this evaluation.
    assign w_num_eff = w_num_wr ? w_num_sat : r_num;
    assign w_last    = ({1'b0, r_idx} == (r_num - 1'b1));

    esop_cube_match #(
        .NUM_VARS (NUM_VARS)
    ) u_match (
        .i_care  (r_care[r_idx]),
        .i_pol   (r_pol[r_idx]),
        .i_x     (r_x),
        .o_match (w_match)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_next = (w_num_eff == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Cube store lives in flops so the whole list clears with the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_care    <= '0;
            r_pol     <= '0;
            r_num     <= '0;
            r_idx     <= '0;
            r_x       <= '0;
            r_acc     <= 1'b0;
            r_hits    <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_drop;
            if (w_cube_wr) begin
                r_care[bus.cfg_addr] <= bus.cfg_care;
                r_pol[bus.cfg_addr]  <= bus.cfg_pol;
            end
            if (w_num_wr) begin
                r_num <= w_num_sat;
            end
            if (w_accept) begin
                r_x    <= bus.in_x;
                r_acc  <= 1'b0;
                r_hits <= '0;
                r_idx  <= '0;
            end else if (w_eval) begin
                r_acc  <= r_acc ^ w_match;
                r_hits <= r_hits + {{CW{1'b0}}, w_match};
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_f     = r_acc;
    assign bus.out_hits  = r_hits;
    assign bus.cfg_err   = r_cfg_err;

endmodule
